givens_apply: RTL and testbench

- Downstream consumer of the Givens coefficient stage in the QR/MIMO-detection datapath.
- Latches one (cos, sin) pair, then streams N_COLS element pairs (x[j], y[j]) from the two matrix rows being rotated.
- Emits the rotated row pairs x'[j], y'[j] in IEEE-754 single precision.
- Built from the codebase's pipelined fp_mul/fp_add units; throughput is one column per cycle.

---
 rtl/float_pkg.sv | 141 ++++++++++++++
 rtl/givens_apply_lane.sv | 79 +++++++
 rtl/givens_apply.sv | 180 ++++++++++++++++++
 tb/tb_givens_apply.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared single-precision float helpers for the Givens datapath.
// Holds format defaults, constants, FSM states and fp_mul/fp_add math.
package float_pkg;

    localparam int DEF_EXP  = 8;
    localparam int DEF_MNT  = 23;
    localparam int DEF_DATA = DEF_EXP + DEF_MNT + 1;

    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_e;

    function automatic logic [31:0] fp_neg(input logic [31:0] v);
        return {~v[31], v[30:0]};
    endfunction

    // Round-to-nearest-even multiply; denormals flush to zero.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        sgn;
        logic [47:0] p;
        logic [24:0] m;
        logic        g;
        logic        st;
        logic [31:0] r;
        int          e;
        sgn = a[31] ^ b[31];
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            e  = e + 1;
            m  = {1'b0, p[47:24]};
            g  = p[23];
            st = |p[22:0];
        end else begin
            m  = {1'b0, p[46:23]};
            g  = p[22];
            st = |p[21:0];
        end
        if (g && (st || m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e = e + 1;
        end
        r = {sgn, 8'(e), m[22:0]};
        if (e >= 255) r = {sgn, 8'hFF, 23'd0};
        if (e <= 0) r = {sgn, 31'd0};
        if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) ||
            (b[30:23] == 8'hFF && b[22:0] != 23'd0) ||
            (a[30:23] == 8'hFF && b[30:23] == 8'd0) ||
            (b[30:23] == 8'hFF && a[30:23] == 8'd0))
            r = FP_QNAN;
        else if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)
            r = {sgn, 8'hFF, 23'd0};
        else if (a[30:23] == 8'd0 || b[30:23] == 8'd0)
            r = {sgn, 31'd0};
        return r;
    endfunction

    // Round-to-nearest-even add with guard/round/sticky; denormals flush to zero.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] hi;
        logic [31:0] lo;
        logic [26:0] mh;
        logic [26:0] ml;
        logic [26:0] sh;
        logic [27:0] sm;
        logic [24:0] m;
        logic        g;
        logic        st;
        logic [31:0] r;
        int          e;
        int          d;
        if (a[30:0] >= b[30:0]) begin
            hi = a;
            lo = b;
        end else begin
            hi = b;
            lo = a;
        end
        e  = int'(hi[30:23]);
        d  = e - int'(lo[30:23]);
        mh = {1'b1, hi[22:0], 3'b000};
        ml = {1'b1, lo[22:0], 3'b000};
        if (d >= 27) begin
            sh = 27'd1;
        end else begin
            sh = ml >> d;
            if ((ml & ((27'd1 << d) - 27'd1)) != 27'd0) sh[0] = 1'b1;
        end
        if (hi[31] == lo[31]) begin
            sm = {1'b0, mh} + {1'b0, sh};
            if (sm[27]) begin
                sm = {1'b0, sm[27:2], sm[1] | sm[0]};
                e  = e + 1;
            end
        end else begin
            sm = {1'b0, mh} - {1'b0, sh};
            for (int i = 0; i < 27; i++) begin
                if (!sm[26] && sm != 28'd0) begin
                    sm = sm << 1;
                    e  = e - 1;
                end
            end
        end
        m  = {1'b0, sm[26:3]};
        g  = sm[2];
        st = sm[1] | sm[0];
        if (g && (st || m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e = e + 1;
        end
        r = {hi[31], 8'(e), m[22:0]};
        if (e >= 255) r = {hi[31], 8'hFF, 23'd0};
        if (e <= 0) r = {hi[31], 31'd0};
        if (sm == 28'd0) r = FP_ZERO;
        if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) ||
            (b[30:23] == 8'hFF && b[22:0] != 23'd0) ||
            (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31]))
            r = FP_QNAN;
        else if (a[30:23] == 8'hFF)
            r = a;
        else if (b[30:23] == 8'hFF)
            r = b;
        else if (a[30:23] == 8'd0 && b[30:23] == 8'd0)
            r = {a[31] & b[31], 31'd0};
        else if (a[30:23] == 8'd0)
            r = b;
        else if (b[30:23] == 8'd0)
            r = a;
        return r;
    endfunction

endpackage

// File: rtl/givens_apply_lane.sv
// One rotation lane: sum = a*p + b*q through pipelined
// multiply, a product register and a pipelined add.
module givens_apply_lane
    import float_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int ADD_LAT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] a,
    input  logic [31:0] p,
    input  logic [31:0] b,
    input  logic [31:0] q,
    output logic [31:0] sum,
    output logic        sum_valid
);

    logic [MUL_LAT-1:0][31:0] ap_q, ap_d, bq_q, bq_d;
    logic [MUL_LAT-1:0]       mv_q, mv_d;
    logic [31:0]              pa_q, pa_d, pb_q, pb_d;
    logic                     pv_q, pv_d;
    logic [ADD_LAT-1:0][31:0] s_q, s_d;
    logic [ADD_LAT-1:0]       sv_q, sv_d;

    // Multiplier pipes, product register and adder pipe advance every cycle.
    always_comb begin
        ap_d = ap_q;
        bq_d = bq_q;
        mv_d = mv_q;
        s_d  = s_q;
        sv_d = sv_q;
        ap_d[0] = fp_mul(a, p);
        bq_d[0] = fp_mul(b, q);
        mv_d[0] = en;
        for (int i = 1; i < MUL_LAT; i++) begin
            ap_d[i] = ap_q[i-1];
            bq_d[i] = bq_q[i-1];
            mv_d[i] = mv_q[i-1];
        end
        pa_d = ap_q[MUL_LAT-1];
        pb_d = bq_q[MUL_LAT-1];
        pv_d = mv_q[MUL_LAT-1];
        s_d[0]  = fp_add(pa_q, pb_q);
        sv_d[0] = pv_q;
        for (int i = 1; i < ADD_LAT; i++) begin
            s_d[i]  = s_q[i-1];
            sv_d[i] = sv_q[i-1];
        end
    end

    // Pipeline state; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            ap_q <= '0;
            bq_q <= '0;
            mv_q <= '0;
            pa_q <= '0;
            pb_q <= '0;
            pv_q <= 1'b0;
            s_q  <= '0;
            sv_q <= '0;
        end else begin
            ap_q <= ap_d;
            bq_q <= bq_d;
            mv_q <= mv_d;
            pa_q <= pa_d;
            pb_q <= pb_d;
            pv_q <= pv_d;
            s_q  <= s_d;
            sv_q <= sv_d;
        end
    end

    assign sum       = s_q[ADD_LAT-1];
    assign sum_valid = sv_q[ADD_LAT-1];

endmodule

// File: rtl/givens_apply.sv
// Applies a latched Givens (cos, sin) pair to N_COLS streamed column pairs:
// x' = c*x + s*y, y' = c*y - s*x, one column per cycle.
module givens_apply
    import float_pkg::*;
#(
    parameter int I_EXP   = DEF_EXP,
    parameter int I_MNT   = DEF_MNT,
    parameter int I_DATA  = I_EXP + I_MNT + 1,
    parameter int N_COLS  = 8,
    parameter int MUL_LAT = 3,
    parameter int ADD_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rot_valid,
    input  logic [I_DATA-1:0] rot_cos,
    input  logic [I_DATA-1:0] rot_sin,
    output logic              rot_ready,
    input  logic              in_valid,
    input  logic [I_DATA-1:0] in_x,
    input  logic [I_DATA-1:0] in_y,
    output logic              in_ready,
    output logic              out_valid,
    output logic [I_DATA-1:0] out_x,
    output logic [I_DATA-1:0] out_y,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int            CW   = $clog2(N_COLS + 1);
    localparam logic [CW-1:0] LAST = CW'(N_COLS - 1);
    localparam logic [CW-1:0] FULL = CW'(N_COLS);

    state_e              state_q, state_d;
    logic [CW-1:0]       in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic [I_DATA-1:0]   cos_q, cos_d, sin_q, sin_d;
    logic [I_DATA-1:0]   sx_q, sx_d, sy_q, sy_d;
    logic                stb_q, stb_d;
    logic [I_DATA-1:0]   ox_q, ox_d, oy_q, oy_d;
    logic                ov_q, ov_d, ol_q, ol_d;
    logic                rr_q, rr_d, ir_q, ir_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic                acc;
    logic [31:0]         lx_sum, ly_sum;
    logic                lx_v, ly_v;

    // Control: column acceptance, counters and state sequencing.
    always_comb begin
        acc       = in_valid && ir_q && (state_q == ST_STREAM);
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        cos_d     = cos_q;
        sin_d     = sin_q;
        out_cnt_d = (lx_v && ly_v) ? out_cnt_q + CW'(1) : out_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rot_valid) begin
                    cos_d     = rot_cos;
                    sin_d     = rot_sin;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    state_d   = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (acc) begin
                    in_cnt_d = in_cnt_q + CW'(1);
                    if (in_cnt_q == LAST) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_cnt_q == FULL) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        rr_d   = (state_d == ST_IDLE);
        ir_d   = (state_d == ST_STREAM) && (in_cnt_d < FULL);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // Datapath: input capture and output register behind both lanes.
    always_comb begin
        sx_d  = in_x;
        sy_d  = in_y;
        stb_d = acc;
        ov_d  = lx_v && ly_v;
        ol_d  = ov_d && (out_cnt_q == LAST);
        ox_d  = lx_sum;
        oy_d  = ly_sum;
    end

    // All state registers; outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            cos_q     <= '0;
            sin_q     <= '0;
            sx_q      <= '0;
            sy_q      <= '0;
            stb_q     <= 1'b0;
            ox_q      <= '0;
            oy_q      <= '0;
            ov_q      <= 1'b0;
            ol_q      <= 1'b0;
            rr_q      <= 1'b1;
            ir_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            cos_q     <= cos_d;
            sin_q     <= sin_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            stb_q     <= stb_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            ov_q      <= ov_d;
            ol_q      <= ol_d;
            rr_q      <= rr_d;
            ir_q      <= ir_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    givens_apply_lane #(.MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT)) u_lane_x (
        .clk       (clk),
        .reset     (reset),
        .en        (stb_q),
        .a         (cos_q),
        .p         (sx_q),
        .b         (sin_q),
        .q         (sy_q),
        .sum       (lx_sum),
        .sum_valid (lx_v)
    );

    givens_apply_lane #(.MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT)) u_lane_y (
        .clk       (clk),
        .reset     (reset),
        .en        (stb_q),
        .a         (cos_q),
        .p         (sy_q),
        .b         (fp_neg(sin_q)),
        .q         (sx_q),
        .sum       (ly_sum),
        .sum_valid (ly_v)
    );

    // Lanes must stay in lockstep and the output count must stay in range.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (I_DATA == I_EXP + I_MNT + 1);
            assert (lx_v == ly_v);
            assert (out_cnt_q <= FULL);
        end
    end

    assign rot_ready = rr_q;
    assign in_ready  = ir_q;
    assign out_valid = ov_q;
    assign out_x     = ox_q;
    assign out_y     = oy_q;
    assign out_last  = ol_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_givens_apply.sv
// Bench for givens_apply: real-arithmetic reference model with a
// per-cycle compare process, plus directed rotations and literal pins.
module tb_givens_apply;

    localparam int N   = 8;
    localparam int ML  = 3;
    localparam int AL  = 4;
    localparam int LAT = ML + AL + 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        rot_valid;
    logic [31:0] rot_cos, rot_sin;
    logic        rot_ready;
    logic        in_valid;
    logic [31:0] in_x, in_y;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_x, out_y;
    logic        out_last;
    logic        busy;
    logic        done;

    givens_apply #(.N_COLS(N), .MUL_LAT(ML), .ADD_LAT(AL)) dut (
        .clk       (clk),
        .reset     (reset),
        .rot_valid (rot_valid),
        .rot_cos   (rot_cos),
        .rot_sin   (rot_sin),
        .rot_ready (rot_ready),
        .in_valid  (in_valid),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] x;
        logic [31:0] y;
        bit          last;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mdl_c, mdl_s;
    int          ncol = 0;
    int          done_due = -1;
    bit          chk_en = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] fl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, req);
        end
    endtask

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) d = {f[31], 63'd0};
        else d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        logic [24:0] m;
        int          e;
        b = $realtobits(r);
        if (b[62:52] == 11'd0) return {b[63], 31'd0};
        e = int'(b[62:52]) - 1023 + 127;
        m = {2'b01, b[51:29]};
        if (b[28] && ((|b[27:0]) || m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e++;
        end
        if (e >= 255) return {b[63], 8'hFF, 23'd0};
        if (e <= 0) return {b[63], 31'd0};
        return {b[63], 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] m_mul(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) * f2r(b));
    endfunction

    function automatic logic [31:0] m_add(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] rot_x(input logic [31:0] c, s, x, y);
        return m_add(m_mul(c, x), m_mul(s, y));
    endfunction

    function automatic logic [31:0] rot_y(input logic [31:0] c, s, x, y);
        return m_add(m_mul(c, y), m_mul(s ^ 32'h8000_0000, x));
    endfunction

    task automatic push(input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        e.due  = cyc + LAT;
        e.x    = rot_x(mdl_c, mdl_s, x, y);
        e.y    = rot_y(mdl_c, mdl_s, x, y);
        e.last = (ncol == N - 1);
        if (e.last) begin
            done_due = e.due + 1;
            ncol = 0;
        end else begin
            ncol++;
        end
        q.push_back(e);
    endtask

    // Per-cycle output comparison against the model queue.
    always @(negedge clk) begin
        if (chk_en) begin
            bit   ev;
            exp_t e;
            ev = (q.size() > 0) && (q[0].due == cyc);
            chk("out_valid", out_valid, 32'(ev));
            if (ev) begin
                e = q.pop_front();
                chk("out_x", out_x, e.x);
                chk("out_y", out_y, e.y);
                chk("out_last", out_last, 32'(e.last));
            end
            chk("done", done, 32'(cyc == done_due));
            if (reset) begin
                q.delete();
                done_due = -1;
                ncol = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] c, input logic [31:0] s);
        tick();
        chk("rot_ready_idle", rot_ready, 1);
        rot_valid = 1'b1;
        rot_cos = c;
        rot_sin = s;
        mdl_c = c;
        mdl_s = s;
        ncol = 0;
        tick();
        rot_valid = 1'b0;
        chk("in_ready_open", in_ready, 1);
        chk("busy_stream", busy, 1);
    endtask

    task automatic col(input logic [31:0] x, input logic [31:0] y);
        in_valid = 1'b1;
        in_x = x;
        in_y = y;
        chk("in_ready_col", in_ready, 1);
        push(x, y);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 60 && cyc <= done_due; k++) tick();
        chk("done_reached", 32'(cyc > done_due), 1);
        chk("rot_ready_after", rot_ready, 1);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit gp [14];
        fl = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
               32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
        gp = '{1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 0, 0, 1, 1};
        reset = 1'b1;
        rot_valid = 1'b0;
        rot_cos = '0;
        rot_sin = '0;
        in_valid = 1'b0;
        in_x = '0;
        in_y = '0;
        repeat (3) tick();
        chk("rst_rot_ready", rot_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_out_x", out_x, 0);
        chk("rst_out_last", out_last, 0);
        chk_en = 1;
        reset = 1'b0;

        chk("pin_ident_x", rot_x(32'h3F80_0000, 0, 32'h40A0_0000, 32'hC0A0_0000), 32'h40A0_0000);
        chk("pin_ident_y", rot_y(32'h3F80_0000, 0, 32'h40A0_0000, 32'hC0A0_0000), 32'hC0A0_0000);
        chk("pin_swap_x", rot_x(0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000), 32'h4040_0000);
        chk("pin_swap_y", rot_y(0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000), 32'hC000_0000);
        chk("pin_345_x", rot_x(32'h3F19_999A, 32'h3F4C_CCCD, 32'h4040_0000, 32'h4080_0000), 32'h40A0_0000);
        chk("pin_345_y", rot_y(32'h3F19_999A, 32'h3F4C_CCCD, 32'h4040_0000, 32'h4080_0000), 32'h0000_0000);
        chk("pin_mul", m_mul(32'h3F19_999A, 32'h4040_0000), 32'h3FE6_6667);

        start(32'h3F80_0000, 32'h0000_0000);
        for (int j = 0; j < N; j++) col(fl[j], fl[j] | 32'h8000_0000);
        chk("in_ready_drop", in_ready, 0);
        chk("busy_drain", busy, 1);
        wait_done();

        start(32'h0000_0000, 32'h3F80_0000);
        for (int j = 0; j < N; j++) col(32'h4000_0000, 32'h4040_0000);
        wait_done();

        start(32'h3F19_999A, 32'h3F4C_CCCD);
        col(32'h4040_0000, 32'h4080_0000);
        for (int j = 1; j < N; j++) col(fl[j], fl[N-1-j] ^ {j[0], 31'd0});
        wait_done();

        start(32'h3F4C_CCCD, 32'hBF19_999A);
        for (int j = 0; j < 14; j++) begin
            if (gp[j]) begin
                col(fl[j % 8] | 32'h8000_0000, fl[(j + 5) % 8]);
            end else begin
                in_valid = 1'b0;
                in_x = 32'hDEAD_BEEF;
                chk("in_ready_gap", in_ready, 1);
                rot_valid = (j == 1);
                rot_cos = 32'h4000_0000;
                rot_sin = 32'h4000_0000;
                tick();
                rot_valid = 1'b0;
            end
        end
        wait_done();

        start(32'h3F80_0000, 32'h3F80_0000);
        for (int j = 0; j < 3; j++) col(fl[j], fl[j + 1]);
        reset = 1'b1;
        tick();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rot_ready", rot_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        reset = 1'b0;
        repeat (15) tick();
        start(32'h3F19_999A, 32'h3F4C_CCCD);
        for (int j = 0; j < N; j++) col(fl[(j + 2) % 8], fl[j]);
        wait_done();

        tick();
        chk("b2b_idle", rot_ready, 1);
        rot_valid = 1'b1;
        rot_cos = 32'h3F80_0000;
        rot_sin = 32'h0000_0000;
        mdl_c = rot_cos;
        mdl_s = rot_sin;
        ncol = 0;
        in_valid = 1'b1;
        in_x = fl[0];
        in_y = fl[3];
        for (int t = 1; t <= 30; t++) begin
            bit r;
            tick();
            r = (t >= 1 && t <= 8) || (t >= 21 && t <= 28);
            if (t == 1) begin
                rot_cos = 32'h3F19_999A;
                rot_sin = 32'h3F4C_CCCD;
            end
            if (t == 19) chk("b2b_done_busy", rot_ready, 0);
            if (t == 20) chk("b2b_idle_gap", rot_ready, 1);
            if (t == 21) begin
                mdl_c = 32'h3F19_999A;
                mdl_s = 32'h3F4C_CCCD;
                rot_valid = 1'b0;
            end
            if (t == 29) in_valid = 1'b0;
            in_x = fl[t % 8];
            in_y = fl[(t + 3) % 8] | 32'h8000_0000;
            chk("b2b_in_ready", in_ready, 32'(r));
            if (r && in_valid) push(in_x, in_y);
        end
        wait_done();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
